// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// slave is the arbiter's view; master is the requester/consumer/ALU environment.
interface alu_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [2:0]  req0_op_i;
  logic [31:0] req0_a_i;
  logic [31:0] req0_b_i;

  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [2:0]  req1_op_i;
  logic [31:0] req1_a_i;
  logic [31:0] req1_b_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_id_o;
  logic [31:0] rsp_data_o;

  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data_i;

  logic        busy_o;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  rsp_ready_i, alu_data_i,
    output req0_ready_o, req1_ready_o,
    output rsp_valid_o, rsp_id_o, rsp_data_o,
    output alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output rsp_ready_i, alu_data_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp_valid_o, rsp_id_o, rsp_data_o,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters; multiply
// operands are held on the ALU inputs for MUL_CYCLES cycles (multicycle path).
module alu_arbiter #(
  parameter int MUL_CYCLES = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);
  localparam int         DATA_W   = 32;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [2:0] OP_MUL   = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              prio;
  logic              grant0, grant1, accept;
  logic [3:0]        cnt;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a, req_b;
  logic [2:0]        op_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              id_p0;
  logic [DATA_W-1:0] rsp_data_p1;

  // prio only breaks ties; a lone valid requester is always granted
  assign grant0 = bus.req0_valid_i & (~bus.req1_valid_i | ~prio);
  assign grant1 = bus.req1_valid_i & (~bus.req0_valid_i | prio);
  assign accept = (state == IDLE) & (grant0 | grant1);

  assign req_op = grant1 ? bus.req1_op_i : bus.req0_op_i;
  assign req_a  = grant1 ? bus.req1_a_i  : bus.req0_a_i;
  assign req_b  = grant1 ? bus.req1_b_i  : bus.req0_b_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready_o = 1'b0;
    bus.req1_ready_o = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.busy_o       = 1'b0;
    bus.alu_ctrl_o   = 3'b000;
    case (state)
      IDLE: begin
        bus.req0_ready_o = grant0 & ~rst_i;
        bus.req1_ready_o = grant1 & ~rst_i;
      end
      EXEC: begin
        bus.busy_o     = 1'b1;
        bus.alu_ctrl_o = op_p0;
      end
      RESP: begin
        bus.busy_o      = 1'b1;
        bus.rsp_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // p0: operands latched at grant; p1: ALU result captured on the last EXEC cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio        <= 1'b0;
      cnt         <= 4'd0;
      op_p0       <= 3'b000;
      a_p0        <= '0;
      b_p0        <= '0;
      id_p0       <= 1'b0;
      rsp_data_p1 <= '0;
    end else if (accept) begin
      op_p0 <= req_op;
      a_p0  <= req_a;
      b_p0  <= req_b;
      id_p0 <= grant1;
      prio  <= ~grant1;
      cnt   <= (req_op == OP_MUL) ? MUL_LAST : 4'd0;
    end else if (state == EXEC) begin
      if (cnt == 4'd0) rsp_data_p1 <= bus.alu_data_i;
      else             cnt         <= cnt - 4'd1;
    end
  end

  assign bus.alu_data1_o = a_p0;
  assign bus.alu_data2_o = b_p0;
  assign bus.rsp_id_o    = id_p0;
  assign bus.rsp_data_o  = rsp_data_p1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, all checked by a
// cycle-level reference model of the arbitration and latency rules.
module tb_alu_arbiter;
  localparam int MUL_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU stand-in: purely combinational, 0 for ctrl 000 and undefined codes
  assign bus.alu_data_i = alu_fn(bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o);

  // Reference model: busy flag, cycles remaining until the result is offered,
  // and the round-robin pointer.
  bit          m_busy, m_prio, m_id;
  int          m_wait;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  bit          acc0, acc1;
  int          rsp_cnt = 0;
  int          mul_seen = 0;
  int          grant_log[$];
  int          rsp_ids[$];

  always @(negedge clk) begin
    bit v0, v1, e0, e1, exec;
    if (rst) begin
      chk("rst_ready0", 32'(bus.req0_ready_o), 32'd0);
      chk("rst_ready1", 32'(bus.req1_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_alu_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
      chk("rst_data1", bus.alu_data1_o, 32'd0);
      chk("rst_data2", bus.alu_data2_o, 32'd0);
      chk("rst_rsp_data", bus.rsp_data_o, 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id_o), 32'd0);
      m_busy = 0; m_prio = 0; m_wait = 0; acc0 = 0; acc1 = 0;
    end else begin
      v0   = bus.req0_valid_i;
      v1   = bus.req1_valid_i;
      e0   = !m_busy && v0 && (!v1 || !m_prio);
      e1   = !m_busy && v1 && (!v0 || m_prio);
      exec = m_busy && (m_wait > 0);
      chk("ready0", 32'(bus.req0_ready_o), 32'(e0));
      chk("ready1", 32'(bus.req1_ready_o), 32'(e1));
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_busy && m_wait == 0));
      chk("busy", 32'(bus.busy_o), 32'(m_busy));
      chk("alu_ctrl", 32'(bus.alu_ctrl_o), exec ? 32'(m_op) : 32'd0);
      if (exec) begin
        chk("alu_data1", bus.alu_data1_o, m_a);
        chk("alu_data2", bus.alu_data2_o, m_b);
        if (bus.alu_ctrl_o == 3'b101) mul_seen++;
      end
      if (m_busy && m_wait == 0) begin
        chk("rsp_data", bus.rsp_data_o, alu_fn(m_op, m_a, m_b));
        chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_id));
      end
      acc0 = e0;
      acc1 = e1;
      if (!m_busy) begin
        if (e0 || e1) begin
          m_busy = 1;
          m_id   = e1;
          m_op   = e1 ? bus.req1_op_i : bus.req0_op_i;
          m_a    = e1 ? bus.req1_a_i : bus.req0_a_i;
          m_b    = e1 ? bus.req1_b_i : bus.req0_b_i;
          m_wait = (m_op == 3'b101) ? MUL_CYCLES : 1;
          m_prio = !e1;
          grant_log.push_back(int'(e1));
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.rsp_ready_i) begin
        m_busy = 0;
        rsp_ids.push_back(int'(m_id));
        rsp_cnt++;
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end
  endtask

  task automatic idle_bus();
    set_req(0, 0, 3'b000, 32'd0, 32'd0);
    set_req(1, 0, 3'b000, 32'd0, 32'd0);
    bus.rsp_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(input bit id, output int t);
    t = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready_o : bus.req0_ready_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("timeout_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("timeout_rsp", 32'd0, 32'd1);
  endtask

  task automatic run_one(input bit id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp);
    int t0, t1;
    @(posedge clk); #1 set_req(id, 1, op, a, b);
    wait_ready(id, t0);
    @(posedge clk); #1 set_req(id, 0, 3'b000, 32'd0, 32'd0);
    wait_rsp(t1);
    if (t0 >= 0 && t1 >= 0) chk("latency", 32'(t1 - t0), 32'(lat));
    chk("one_data", bus.rsp_data_o, exp);
    chk("one_id", 32'(bus.rsp_id_o), 32'(id));
  endtask

  function automatic logic [2:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 3'b101;
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, tr, n0;
    rst = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single add from requester 0
    run_one(0, 3'b001, 32'd5, 32'd7, 2, 32'd12);

    // both requesters contend continuously: grants alternate from 0
    do_reset();
    grant_log.delete();
    rsp_ids.delete();
    @(posedge clk); #1;
    set_req(0, 1, 3'b010, 32'd10, 32'd3);
    set_req(1, 1, 3'b011, 32'h0000_00F0, 32'h0000_003C);
    for (int k = 0; k < 60 && grant_log.size() < 4; k++) @(negedge clk);
    @(posedge clk); #1 idle_bus();
    for (int k = 0; k < 60 && rsp_ids.size() < 4; k++) @(negedge clk);
    chk("rr_grants", 32'(grant_log.size()), 32'd4);
    chk("rr_rsps", 32'(rsp_ids.size()), 32'd4);
    if (grant_log.size() >= 4 && rsp_ids.size() >= 4) begin
      n0 = 0;
      for (int i = 0; i < 4; i++) begin
        chk("rr_grant_order", 32'(grant_log[i]), 32'(i % 2));
        chk("rr_rsp_order", 32'(rsp_ids[i]), 32'(i % 2));
        if (rsp_ids[i] == 0) n0++;
      end
      chk("rr_share0", 32'(n0), 32'd2);
    end

    // multiply: operands held MUL_CYCLES cycles, product wraps to 0
    do_reset();
    mul_seen = 0;
    run_one(1, 3'b101, 32'h0001_0000, 32'h0001_0000, MUL_CYCLES + 1, 32'd0);
    chk("mul_hold", 32'(mul_seen), 32'(MUL_CYCLES));

    // response back-pressure with requester 0 still pending
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    set_req(0, 1, 3'b001, 32'd3, 32'd4);
    wait_ready(0, t0);
    @(posedge clk); #1 set_req(0, 1, 3'b100, 32'h0000_0F00, 32'h0000_00F0);
    wait_rsp(t1);
    chk("stall_first", bus.rsp_data_o, 32'd7);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("stall_data", bus.rsp_data_o, 32'd7);
      chk("stall_id", 32'(bus.rsp_id_o), 32'd0);
      chk("stall_ready0", 32'(bus.req0_ready_o), 32'd0);
    end
    @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
    tr = cyc;
    wait_ready(0, t0);
    if (t0 >= 0) chk("stall_regrant", 32'(t0 - tr), 32'd1);
    @(posedge clk); #1 set_req(0, 0, 3'b000, 32'd0, 32'd0);
    wait_rsp(t1);
    chk("stall_second", bus.rsp_data_o, 32'h0000_0FF0);

    // undefined op is accepted and yields 0
    run_one(0, 3'b111, 32'd1, 32'd1, 2, 32'd0);

    // reset during the second EXEC cycle of a multiply
    do_reset();
    @(posedge clk); #1 set_req(0, 1, 3'b101, 32'd3, 32'd4);
    wait_ready(0, t0);
    @(posedge clk); #1 set_req(0, 0, 3'b000, 32'd0, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
    chk("midrst_data1", bus.alu_data1_o, 32'd0);
    chk("midrst_rsp_data", bus.rsp_data_o, 32'd0);
    n0 = rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_one(1, 3'b001, 32'd1, 32'd1, 2, 32'd2);
    @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt - n0), 32'd1);

    // random traffic, random back-pressure, occasional cancellations
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (acc0 || !bus.req0_valid_i)
        set_req(0, bit'($urandom_range(0, 2) != 0), rand_op(), rand_val(), rand_val());
      else if ($urandom_range(0, 19) == 0)
        bus.req0_valid_i = 1'b0;
      if (acc1 || !bus.req1_valid_i)
        set_req(1, bit'($urandom_range(0, 2) != 0), rand_op(), rand_val(), rand_val());
      else if ($urandom_range(0, 19) == 0)
        bus.req1_valid_i = 1'b0;
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 idle_bus();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", 32'(bus.busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
